// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // valid already folds in "writes the register file"
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 is_load;
    } sb_entry_t;

    function automatic logic is_producer(input sb_entry_t e, input logic [REG_IDX_W-1:0] r);
        return e.valid && (e.rd == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall and EX operand forwarding control for a five-stage pipeline,
// driven by a three-entry destination scoreboard (E, M, W).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_writes,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    sb_entry_t  e_q, m_q, w_q;
    sb_entry_t  e_d;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic [1:0] sel_a, sel_b;
    logic       accept;

    // W is tracked but resolves to the register file: write-before-read in the same cycle.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_W-1:0] r);
        logic [1:0] sel;
        sel = FWD_RF;
        if (!uses) begin
            sel = FWD_RF;
        end else if (is_producer(e_q, r) && !e_q.is_load) begin
            sel = FWD_MEM;
        end else if (is_producer(m_q, r)) begin
            sel = FWD_WB;
        end else if (is_producer(w_q, r)) begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    always_comb begin
        stall = 1'b0;
        if (id_valid && !flush && e_q.is_load) begin
            stall = (id_uses_rs && is_producer(e_q, id_rs)) ||
                    (id_uses_rt && is_producer(e_q, id_rt));
        end
    end

    assign accept = id_valid && !stall && !flush;

    always_comb begin
        sel_a = fwd_sel(id_uses_rs, id_rs);
        sel_b = fwd_sel(id_uses_rt, id_rt);

        e_d         = '0;
        e_d.valid   = accept && id_writes;
        e_d.rd      = id_rd;
        e_d.is_load = id_is_load;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            e_q     <= e_d;
            m_q     <= e_q;
            w_q     <= m_q;
            fwd_a_q <= accept ? sel_a : FWD_RF;
            fwd_b_q <= accept ? sel_b : FWD_RF;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clock(clock),
        .reset(reset),
        .inc  (stall),
        .clear(1'b0),
        .count(stall_count)
    );

endmodule
